// File: rtl/riscv_pc_gen.sv
// riscv_pc_gen: next-PC generator for the kana core front end.
// Chooses the next PC from trap, mret, jump, taken branch or sequential sources
// (in that priority) and presents it to I-fetch over a valid/ready handshake.
// A redirect that arrives while fetch is back-pressured is parked in a
// one-deep pending slot. Misaligned non-trap targets are rejected and reported.
// Optional build macro: RISCV_PC_PERF_EN adds saturating redirect/stall counters.
module riscv_pc_gen #(
    parameter int                       WORD_LENGTH  = 32,
    parameter int                       PC_OFFSET    = 4,
    parameter logic [WORD_LENGTH-1:0]   RESET_VECTOR = '0,
    parameter int                       CAUSE_W      = 4
) (
    input  logic                          clk,
    input  logic                          x_reset,
    input  logic                          stall,
    input  logic                          br_valid,
    input  logic                          br_flag,
    input  logic signed [WORD_LENGTH-1:0] imm_b_sext,
    input  logic                          jump_valid,
    input  logic [WORD_LENGTH-1:0]        alu_out,
    input  logic                          trap_valid,
    input  logic                          trap_is_irq,
    input  logic [CAUSE_W-1:0]            trap_cause,
    input  logic [WORD_LENGTH-1:0]        mtvec,
    input  logic                          mret_valid,
    input  logic [WORD_LENGTH-1:0]        mepc,
    input  logic                          fetch_ready,
`ifdef RISCV_PC_PERF_EN
    output logic [31:0]                   redirect_cnt,
    output logic [31:0]                   stall_cnt,
`endif
    output logic                          fetch_valid,
    output logic [WORD_LENGTH-1:0]        pc_out,
    output logic [WORD_LENGTH-1:0]        pc_plus4,
    output logic                          misalign_err,
    output logic [WORD_LENGTH-1:0]        misalign_addr
);

    localparam int             W      = WORD_LENGTH;
    localparam logic [W-1:0]   PC_INC = W'(PC_OFFSET);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] pc;
    logic [W-1:0] pend_target;

    logic [W-1:0] trap_base;
    logic [W-1:0] trap_tgt;
    logic [W-1:0] redir_tgt;
    logic         redir_req;
    logic         redir_is_trap;
    logic         redir_misal;
    logic         redir_ok;
    logic         accept;

    assign pc_out    = pc;
    assign pc_plus4  = pc + PC_INC;
    assign accept    = fetch_valid & fetch_ready;

    // Trap vector: base with MODE bits cleared, plus 4*cause for vectored interrupts
    assign trap_base = {mtvec[W-1:2], 2'b00};
    assign trap_tgt  = (mtvec[1:0] == 2'b01 && trap_is_irq)
                     ? trap_base + {{(W-CAUSE_W-2){1'b0}}, trap_cause, 2'b00}
                     : trap_base;

    // Fixed-priority redirect select; stall suppresses everything but a trap
    always_comb begin
        redir_req     = 1'b0;
        redir_is_trap = 1'b0;
        redir_tgt     = pc;
        if (trap_valid) begin
            redir_req     = 1'b1;
            redir_is_trap = 1'b1;
            redir_tgt     = trap_tgt;
        end else if (!stall) begin
            if (mret_valid) begin
                redir_req = 1'b1;
                redir_tgt = mepc;
            end else if (jump_valid) begin
                redir_req = 1'b1;
                redir_tgt = {alu_out[W-1:1], 1'b0};
            end else if (br_valid && br_flag) begin
                redir_req = 1'b1;
                redir_tgt = pc + $unsigned(imm_b_sext);
            end
        end
    end

    // Trap targets are word aligned by construction, so only the others are checked
    assign redir_misal = redir_req && !redir_is_trap && (redir_tgt[1:0] != 2'b00);
    assign redir_ok    = redir_req && !redir_misal;

    // Control FSM: owns pc, handshake valid and the misalignment report
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            fetch_valid   <= 1'b0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_err <= redir_misal;
            if (redir_misal) begin
                misalign_addr <= redir_tgt;
            end
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                    if (redir_ok) begin
                        pc <= redir_tgt;
                    end
                end
                RUN: begin
                    if (redir_ok) begin
                        if (accept) begin
                            pc <= redir_tgt;
                        end else begin
                            state <= PEND;
                        end
                    end else if (accept && !stall && !redir_misal) begin
                        pc <= pc + PC_INC;
                    end
                end
                PEND: begin
                    // A redirect arriving on the accepting cycle is the newest one
                    if (accept) begin
                        pc    <= redir_ok ? redir_tgt : pend_target;
                        state <= RUN;
                    end
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    // Pending redirect target; newest redirect wins while fetch is held off
    always_ff @(posedge clk) begin
        if (redir_ok && fetch_valid && !fetch_ready) begin
            pend_target <= redir_tgt;
        end
    end

`ifdef RISCV_PC_PERF_EN
    logic redir_applied;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign redir_applied = (state == BOOT && redir_ok)
                        || (state == RUN  && redir_ok && accept)
                        || (state == PEND && accept);

    // Saturating counters for applied redirects and stalled active cycles
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (redir_applied) begin
                redirect_cnt <= sat_inc(redirect_cnt);
            end
            if (stall && state != BOOT) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_pc_gen.sv
// tb_riscv_pc_gen: directed bench for riscv_pc_gen with a fetch scoreboard.
// The stimulus thread pushes the PC it expects fetch to accept each cycle;
// a negedge monitor pops and compares on every valid&ready handshake.
module tb_riscv_pc_gen;

    localparam int W = 32;

    logic                 clk = 1'b0;
    logic                 x_reset;
    logic                 stall;
    logic                 br_valid;
    logic                 br_flag;
    logic signed [W-1:0]  imm_b_sext;
    logic                 jump_valid;
    logic [W-1:0]         alu_out;
    logic                 trap_valid;
    logic                 trap_is_irq;
    logic [3:0]           trap_cause;
    logic [W-1:0]         mtvec;
    logic                 mret_valid;
    logic [W-1:0]         mepc;
    logic                 fetch_ready;
    logic                 fetch_valid;
    logic [W-1:0]         pc_out;
    logic [W-1:0]         pc_plus4;
    logic                 misalign_err;
    logic [W-1:0]         misalign_addr;
`ifdef RISCV_PC_PERF_EN
    logic [31:0]          redirect_cnt;
    logic [31:0]          stall_cnt;
`endif

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_pc;

    always #5 clk = ~clk;

    riscv_pc_gen #(
        .WORD_LENGTH (32),
        .PC_OFFSET   (4),
        .RESET_VECTOR(32'h0),
        .CAUSE_W     (4)
    ) dut (
        .clk          (clk),
        .x_reset      (x_reset),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_flag      (br_flag),
        .imm_b_sext   (imm_b_sext),
        .jump_valid   (jump_valid),
        .alu_out      (alu_out),
        .trap_valid   (trap_valid),
        .trap_is_irq  (trap_is_irq),
        .trap_cause   (trap_cause),
        .mtvec        (mtvec),
        .mret_valid   (mret_valid),
        .mepc         (mepc),
        .fetch_ready  (fetch_ready),
`ifdef RISCV_PC_PERF_EN
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .fetch_valid  (fetch_valid),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err),
        .misalign_addr(misalign_addr)
    );

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Monitor: every accepted fetch must match the next expected PC
    always @(negedge clk) begin
        if (fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fetch: got pc 0x%0h, required no handshake", pc_out);
            end else begin
                exp_pc = exp_q.pop_front();
                check("fetch_pc", pc_out, exp_pc);
                check("fetch_pc_plus4", pc_plus4, exp_pc + 32'd4);
            end
        end
    end

    task automatic step(input bit push, input logic [W-1:0] pc_exp);
        if (push) exp_q.push_back(pc_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall       = 1'b0;
        br_valid    = 1'b0;
        br_flag     = 1'b0;
        imm_b_sext  = '0;
        jump_valid  = 1'b0;
        alu_out     = '0;
        trap_valid  = 1'b0;
        trap_is_irq = 1'b0;
        trap_cause  = '0;
        mtvec       = '0;
        mret_valid  = 1'b0;
        mepc        = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        x_reset     = 1'b0;
        fetch_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc_out, 32'h0);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_misalign_err", {31'b0, misalign_err}, 32'd0);
        check("rst_misalign_addr", misalign_addr, 32'h0);

        // Reset release: one BOOT cycle, then sequential fetch
        @(negedge clk);
        x_reset = 1'b1;
        @(posedge clk);
        #1;
        check("boot_to_run_valid", {31'b0, fetch_valid}, 32'd1);
        step(1, 32'h0);
        step(1, 32'h4);
        step(1, 32'h8);

        // Jump to 0x100, taken branch -8, then not-taken branch
        jump_valid = 1'b1; alu_out = 32'h100;
        step(1, 32'hC);
        clr();
        br_valid = 1'b1; br_flag = 1'b1; imm_b_sext = -32'sd8;
        step(1, 32'h100);
        clr();
        jump_valid = 1'b1; alu_out = 32'h100;
        step(1, 32'hF8);
        clr();
        br_valid = 1'b1; br_flag = 1'b0; imm_b_sext = -32'sd8;
        step(1, 32'h100);
        clr();
        step(1, 32'h104);

        // Back-pressured jump parks in the pending slot
        jump_valid = 1'b1; alu_out = 32'h40;
        step(1, 32'h108);
        clr();
        fetch_ready = 1'b0;
        jump_valid = 1'b1; alu_out = 32'h201;
        step(0, 32'h0);
        clr();
        check("pend_pc_hold1", pc_out, 32'h40);
        check("pend_fetch_valid", {31'b0, fetch_valid}, 32'd1);
        step(0, 32'h0);
        check("pend_pc_hold2", pc_out, 32'h40);
        fetch_ready = 1'b1;
        step(1, 32'h40);
        step(1, 32'h200);

        // Vectored trap beats a misaligned jump and a stall
        trap_valid = 1'b1; trap_is_irq = 1'b1; trap_cause = 4'd3; mtvec = 32'h1001;
        jump_valid = 1'b1; alu_out = 32'h122; stall = 1'b1;
        step(1, 32'h204);
        check("trap_vec_pc", pc_out, 32'h100C);
        check("trap_no_misalign", {31'b0, misalign_err}, 32'd0);
        clr();
        stall = 1'b1;
        step(1, 32'h100C);
        stall = 1'b1; jump_valid = 1'b1; alu_out = 32'h800;
        step(1, 32'h100C);
        check("stall_jump_ignored", pc_out, 32'h100C);
        clr();
        step(1, 32'h100C);

        // Direct-mode trap and vectored-mode exception both use the base
        trap_valid = 1'b1; trap_is_irq = 1'b1; trap_cause = 4'd5; mtvec = 32'h2000;
        step(1, 32'h1010);
        clr();
        trap_valid = 1'b1; trap_is_irq = 1'b0; trap_cause = 4'd7; mtvec = 32'h3001;
        step(1, 32'h2000);
        clr();

        // Misaligned jump: pulse, address captured, pc unchanged
        jump_valid = 1'b1; alu_out = 32'h122;
        step(1, 32'h3000);
        check("misal_jump_err", {31'b0, misalign_err}, 32'd1);
        check("misal_jump_addr", misalign_addr, 32'h122);
        check("misal_jump_pc", pc_out, 32'h3000);
        clr();
        step(1, 32'h3000);
        check("misal_pulse_end", {31'b0, misalign_err}, 32'd0);
        check("misal_addr_held", misalign_addr, 32'h122);

        // mret outranks jump; misaligned taken branch
        mret_valid = 1'b1; mepc = 32'h500; jump_valid = 1'b1; alu_out = 32'h600;
        step(1, 32'h3004);
        clr();
        br_valid = 1'b1; br_flag = 1'b1; imm_b_sext = 32'sd2;
        step(1, 32'h500);
        check("misal_br_err", {31'b0, misalign_err}, 32'd1);
        check("misal_br_addr", misalign_addr, 32'h502);
        clr();
        step(1, 32'h500);

        // Wrap-around at the top of the address space
        jump_valid = 1'b1; alu_out = 32'hFFFF_FFFC;
        step(1, 32'h504);
        clr();
        step(1, 32'hFFFF_FFFC);
        step(1, 32'h0);

        // Reset while a redirect is pending
        fetch_ready = 1'b0;
        jump_valid = 1'b1; alu_out = 32'h700;
        step(0, 32'h0);
        clr();
        check("pend_before_reset", pc_out, 32'h4);
        #2;
        x_reset = 1'b0;
        #1;
        check("async_rst_pc", pc_out, 32'h0);
        check("async_rst_valid", {31'b0, fetch_valid}, 32'd0);
        fetch_ready = 1'b1;
        @(negedge clk);
        x_reset = 1'b1;
        @(posedge clk);
        #1;
        step(1, 32'h0);
        step(1, 32'h4);
        fetch_ready = 1'b0;
        step(0, 32'h0);
        step(0, 32'h0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
